// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: Tuse/Tnew stall and forwarding control for a 5-stage
// pipeline, with an internal E/M/W shadow of destination and Tnew, plus a
// busy counter for the multi-cycle multiply/divide unit (HI/LO users stall).
// Decoded fields arrive once at D; the shadow follows the pipeline and turns
// a stall into a bubble in E on the same edge the core does.
`timescale 1ns/1ps
module hazard_unit_mdu #(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [AW-1:0] a3_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          md_use_d,
  input  logic          md_start_e,
  input  logic          md_div_e,
  output logic          stall_pc,
  output logic          stall_d,
  output logic          clr_e,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          md_busy
);

  // All-ones Tuse means the operand is not read at all.
  localparam logic [TW-1:0] TUSE_NONE = {TW{1'b1}};
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  // Shadow pipeline state
  logic [AW-1:0] rs_e, rt_e, a3_e, a3_m, a3_w;
  logic [TW-1:0] tnew_e, tnew_m, tnew_w;
  logic [CW-1:0] md_cnt;

  logic stall;
  logic stall_rs, stall_rt, stall_md;

  // Register 0 is hard-wired zero, so it never matches a producer.
  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] s);
    return (a != '0) && (a == s);
  endfunction

  // Tnew counts down one per stage and saturates at "ready".
  function automatic logic [TW-1:0] satdec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // Operand stall: a producer in E or M that will not be ready in time.
  function automatic logic op_stall(input logic [AW-1:0] a, input logic [TW-1:0] tuse,
                                    input logic [AW-1:0] ae, input logic [TW-1:0] te,
                                    input logic [AW-1:0] am, input logic [TW-1:0] tm);
    return (tuse != TUSE_NONE) &&
           ((match(a, ae) && (tuse < te)) || (match(a, am) && (tuse < tm)));
  endfunction

  // D-stage source select. The newest matching stage decides; if it is not
  // ready yet, older stages hold a stale value, so select the register file.
  function automatic logic [1:0] sel_d(input logic [AW-1:0] a,
                                       input logic [AW-1:0] ae, input logic [TW-1:0] te,
                                       input logic [AW-1:0] am, input logic [TW-1:0] tm,
                                       input logic [AW-1:0] aw, input logic [TW-1:0] tw);
    if (match(a, ae))      return (te == '0) ? 2'd3 : 2'd0;
    else if (match(a, am)) return (tm == '0) ? 2'd2 : 2'd0;
    else if (match(a, aw)) return (tw == '0) ? 2'd1 : 2'd0;
    else                   return 2'd0;
  endfunction

  // E-stage source select, same newest-wins rule over M then W.
  function automatic logic [1:0] sel_e(input logic [AW-1:0] a,
                                       input logic [AW-1:0] am, input logic [TW-1:0] tm,
                                       input logic [AW-1:0] aw, input logic [TW-1:0] tw);
    if (match(a, am))      return (tm == '0) ? 2'd2 : 2'd0;
    else if (match(a, aw)) return (tw == '0) ? 2'd1 : 2'd0;
    else                   return 2'd0;
  endfunction

  // Stall decision: data hazards on either operand, or a HI/LO user while the MDU works.
  always_comb begin
    stall_rs = op_stall(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
    stall_rt = op_stall(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
    stall_md = md_use_d && (md_start_e || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign stall_pc = stall;
  assign stall_d  = stall;
  assign clr_e    = stall;
  assign md_busy  = (md_cnt != '0);

  // Forwarding selects for the D and E stage operands.
  always_comb begin
    fwd_rs_d = sel_d(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    fwd_rt_d = sel_d(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    fwd_rs_e = sel_e(rs_e, a3_m, tnew_m, a3_w, tnew_w);
    fwd_rt_e = sel_e(rt_e, a3_m, tnew_m, a3_w, tnew_w);
  end

  // Shadow pipeline advance; a stall loads a bubble into E like the core's clr_e.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_e   <= '0;
      rt_e   <= '0;
      a3_e   <= '0;
      tnew_e <= '0;
      a3_m   <= '0;
      tnew_m <= '0;
      a3_w   <= '0;
      tnew_w <= '0;
    end else begin
      if (stall) begin
        rs_e   <= '0;
        rt_e   <= '0;
        a3_e   <= '0;
        tnew_e <= '0;
      end else begin
        rs_e   <= rs_d;
        rt_e   <= rt_d;
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
      end
      a3_m   <= a3_e;
      tnew_m <= satdec(tnew_e);
      a3_w   <= a3_m;
      tnew_w <= satdec(tnew_m);
    end
  end

  // MDU busy counter: a new start always reloads, otherwise count down to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (md_start_e) begin
      md_cnt <= md_div_e ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// tb_hazard_unit_mdu: cycle-by-cycle vector table for the stall/forward
// logic, then hand-written sequences for MDU busy length, start override and
// asynchronous reset in the middle of a divide.
`timescale 1ns/1ps
module tb_hazard_unit_mdu;

  localparam int AW = 5;
  localparam int TW = 2;
  localparam int NV = 17;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] rs_d, rt_d, a3_d;
  logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic          md_use_d, md_start_e, md_div_e;
  logic          stall_pc, stall_d, clr_e, md_busy;
  logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  hazard_unit_mdu #(.AW(AW), .TW(TW), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .tuse_rs_d  (tuse_rs_d),
    .tuse_rt_d  (tuse_rt_d),
    .a3_d       (a3_d),
    .tnew_d     (tnew_d),
    .md_use_d   (md_use_d),
    .md_start_e (md_start_e),
    .md_div_e   (md_div_e),
    .stall_pc   (stall_pc),
    .stall_d    (stall_d),
    .clr_e      (clr_e),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .md_busy    (md_busy)
  );

  typedef struct {
    logic [AW-1:0] rs, rt;
    logic [TW-1:0] tur, tut;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
    logic          st;
    logic [1:0]    frd, frt, fre, fte;
  } vec_t;

  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Scoreboard
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [11:0] outs();
    return {stall_pc, stall_d, clr_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy};
  endfunction

  function automatic vec_t mk(input int rs, input int rt, input int tur, input int tut,
                              input int a3, input int tnew, input int st,
                              input int frd, input int frt, input int fre, input int fte);
    vec_t v;
    v.rs = AW'(rs); v.rt = AW'(rt); v.tur = TW'(tur); v.tut = TW'(tut);
    v.a3 = AW'(a3); v.tnew = TW'(tnew); v.st = st[0];
    v.frd = frd[1:0]; v.frt = frt[1:0]; v.fre = fre[1:0]; v.fte = fte[1:0];
    return v;
  endfunction

  // Driver tasks
  task automatic drive_d(input int rs, input int rt, input int tur, input int tut,
                         input int a3, input int tnew, input logic mu);
    rs_d = AW'(rs); rt_d = AW'(rt); tuse_rs_d = TW'(tur); tuse_rt_d = TW'(tut);
    a3_d = AW'(a3); tnew_d = TW'(tnew); md_use_d = mu;
  endtask

  task automatic drive_nop();
    drive_d(0, 0, 3, 3, 0, 0, 1'b0);
  endtask

  // Issue a mult/div with a HI/LO reader in D; return how many cycles stall stays high.
  task automatic mdu_stall_len(input logic is_div, output int n);
    bit done;
    n = 0;
    done = 0;
    drive_d(0, 0, 3, 3, 8, 1, 1'b1);
    md_start_e = 1'b1;
    md_div_e   = is_div;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall_pc) n++;
      else done = 1;
      @(negedge clk);
      md_start_e = 1'b0;
      md_div_e   = 1'b0;
    end
    drive_nop();
  endtask

  initial begin
    int n;
    bit done;

    // Table: each row is one cycle of D-stage inputs and the outputs in that cycle.
    vecs[0]  = mk( 0, 0, 3, 3,  0, 0, 0, 0, 0, 0, 0);  // nop right after reset
    vecs[1]  = mk( 5, 0, 1, 3,  1, 2, 0, 0, 0, 0, 0);  // lw $1
    vecs[2]  = mk( 1, 3, 1, 1,  2, 1, 1, 0, 0, 0, 0);  // addu $2,$1,$3 load-use stall
    vecs[3]  = mk( 1, 3, 1, 1,  2, 1, 0, 0, 0, 0, 0);  // retry: M not ready, select RF
    vecs[4]  = mk( 0, 0, 3, 3,  0, 0, 0, 0, 0, 1, 0);  // addu in E takes $1 from W
    vecs[5]  = mk( 6, 7, 1, 1,  4, 1, 0, 0, 0, 0, 0);  // addu $4
    vecs[6]  = mk( 4, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);  // beq $4,$0 stall
    vecs[7]  = mk( 4, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0);  // retry: $4 from M, $0 from RF
    vecs[8]  = mk( 0, 0, 3, 3, 31, 0, 0, 0, 0, 1, 0);  // jal; beq in E takes $4 from W
    vecs[9]  = mk(31, 0, 0, 3,  0, 0, 0, 3, 0, 0, 0);  // jr $31 from E, no stall
    vecs[10] = mk(31, 0, 0, 3,  0, 0, 0, 2, 0, 2, 0);  // jr again: from M; E jr from M
    vecs[11] = mk( 5, 0, 1, 3,  0, 2, 0, 0, 0, 1, 0);  // lw $0; E jr from W
    vecs[12] = mk( 0, 0, 1, 1,  2, 1, 0, 0, 0, 0, 0);  // addu $2,$0,$0 never stalls
    vecs[13] = mk( 8, 9, 1, 1,  2, 1, 0, 0, 0, 0, 0);  // addu $2
    vecs[14] = mk( 2, 3, 2, 3,  0, 0, 0, 0, 0, 0, 0);  // E $2 not ready blocks ready M $2
    vecs[15] = mk( 0, 0, 3, 3,  0, 0, 0, 0, 0, 2, 0);  // E reader: M beats W on $2
    vecs[16] = mk( 0, 0, 3, 3,  0, 0, 0, 0, 0, 0, 0);  // quiet

    rst_n = 1'b0;
    md_start_e = 1'b0;
    md_div_e   = 1'b0;
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_outputs", int'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive_d(int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].tur), int'(vecs[i].tut),
              int'(vecs[i].a3), int'(vecs[i].tnew), 1'b0);
      #1;
      check($sformatf("vec%0d", i), int'(outs()),
            int'({{3{vecs[i].st}}, vecs[i].frd, vecs[i].frt, vecs[i].fre, vecs[i].fte, 1'b0}));
      @(negedge clk);
    end

    // mflo right behind a mult, then right behind a div
    mdu_stall_len(1'b0, n);
    check("mult_stall_cycles", n, 6);
    #1 check("mult_idle_after", int'(md_busy), 0);
    @(negedge clk);
    mdu_stall_len(1'b1, n);
    check("div_stall_cycles", n, 11);
    #1 check("div_idle_after", int'(md_busy), 0);
    @(negedge clk);

    // Unrelated addu behind a busy divide, then a mult overriding the count
    drive_d(6, 7, 1, 1, 9, 1, 1'b0);
    md_start_e = 1'b1;
    md_div_e   = 1'b1;
    #1 check("div_issue_no_stall", int'(stall_pc), 0);
    @(negedge clk);
    md_start_e = 1'b0;
    md_div_e   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("div_unrelated%0d", i), int'({stall_pc, md_busy}), 1);
      @(negedge clk);
    end
    md_start_e = 1'b1;
    #1 check("override_busy", int'(md_busy), 1);
    @(negedge clk);
    md_start_e = 1'b0;
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (md_busy) n++;
      else done = 1;
      @(negedge clk);
    end
    check("override_busy_cycles", n, 5);

    // Reset in the middle of a divide with a load-use hazard pending
    drive_nop();
    md_start_e = 1'b1;
    md_div_e   = 1'b1;
    @(negedge clk);
    md_start_e = 1'b0;
    md_div_e   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_d(5, 0, 1, 3, 1, 2, 1'b0);
    @(negedge clk);
    drive_d(1, 3, 1, 1, 2, 1, 1'b1);
    #1 check("pre_reset_stall_busy", int'({stall_pc, md_busy}), 3);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    @(posedge clk);
    #1 check("reset_hold_outputs", int'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_d(1, 3, 1, 1, 2, 1, 1'b1);
    #1 check("post_reset_addu", int'(outs()), 0);
    drive_d(1, 1, 0, 0, 0, 0, 1'b0);
    #1 check("post_reset_beq", int'(outs()), 0);
    drive_d(31, 8, 0, 0, 3, 1, 1'b1);
    #1 check("post_reset_jr_md", int'(outs()), 0);
    @(negedge clk);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
